// File: rtl/seven_segment_pkg.sv
// Shared seven-segment definitions: hex glyphs (abcdefg, bit 6 = a, active-high),
// the blank pattern and a polarity helper used by all display blocks.
package seven_segment_pkg;

  localparam logic [6:0] SEG_OFF = 7'b0000000;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b0011111;
  localparam logic [6:0] SEG_C = 7'b1001110;
  localparam logic [6:0] SEG_D = 7'b0111101;
  localparam logic [6:0] SEG_E = 7'b1001111;
  localparam logic [6:0] SEG_F = 7'b1000111;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
    logic [6:0] seg;
    case (value)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

  // Converts an active-high segment pattern to pin polarity.
  function automatic logic [6:0] seg_pol(input logic [6:0] seg, input logic active_low);
    return seg ^ {7{active_low}};
  endfunction

  function automatic logic bit_pol(input logic value, input logic active_low);
    return value ^ active_low;
  endfunction

endpackage

// File: rtl/seven_segment_digit.sv
// Hex digit to active-high segment pattern, with an override to blank the glyph.
module seven_segment_digit
  import seven_segment_pkg::*;
(
  input  logic [3:0] value,
  input  logic       suppress,
  output logic [6:0] abcdefg
);

  assign abcdefg = suppress ? SEG_OFF : hex_to_seg(value);

endmodule

// File: rtl/seven_segment_scan.sv
// Multiplexed seven-segment scan engine: per-frame snapshot, leading-zero
// suppression, blanking, PWM brightness, dead time and output polarity.
module seven_segment_scan
  import seven_segment_pkg::*;
#(
  parameter int n_digits       = 8,
  parameter int bits_per_digit = 4,
  parameter int w              = n_digits * bits_per_digit,
  parameter int div_w          = 10,
  parameter int bright_w       = 4,
  parameter int guard          = 2,
  parameter bit active_low     = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [w-1:0]        num,
  input  logic [n_digits-1:0] dots,
  input  logic [n_digits-1:0] blank,
  input  logic                lz_en,
  input  logic [bright_w-1:0] brightness,
  output logic [6:0]          abcdefg,
  output logic                dot,
  output logic [n_digits-1:0] anodes,
  output logic                frame_start
);

  localparam int                idx_w    = (n_digits > 1) ? $clog2(n_digits) : 1;
  localparam logic [idx_w-1:0]  idx_last = idx_w'(n_digits - 1);
  localparam logic [div_w-1:0]  cnt_max  = '1;
  localparam logic [div_w-1:0]  guard_c  = div_w'(guard);

  logic [div_w-1:0]    cnt_p0;
  logic [idx_w-1:0]    idx_p0;
  logic [w-1:0]        num_s;
  logic [n_digits-1:0] dots_s;
  logic [n_digits-1:0] blank_s;
  logic [n_digits-1:0] lz_mask_s;
  logic [n_digits-1:0] lz_mask_d;

  logic                slot_end;
  logic                frame_end;
  logic                lit;
  logic [3:0]          digit_val;
  logic [6:0]          seg_dec;
  logic [n_digits-1:0] onehot;

  logic [6:0]          seg_p1;
  logic                dot_p1;
  logic [n_digits-1:0] an_p1;
  logic                frame_start_p1;

  assign slot_end  = (cnt_p0 == cnt_max);
  assign frame_end = slot_end && (idx_p0 == idx_last);

  // Scan from the top digit down; zeros stay dark until the first nonzero digit.
  always_comb begin
    logic suppress;
    lz_mask_d = '0;
    suppress  = lz_en;
    for (int i = n_digits - 1; i >= 1; i--) begin
      if (num[i*4 +: 4] != 4'd0) suppress = 1'b0;
      lz_mask_d[i] = suppress;
    end
  end

  assign digit_val = num_s[{idx_p0, 2'b00} +: 4];

  // Dead time at slot start, then a PWM window set by the top bits of cnt.
  assign lit = en && !blank_s[idx_p0] && (cnt_p0 >= guard_c) &&
               (cnt_p0[div_w-1 -: bright_w] <= brightness);

  always_comb begin
    onehot         = '0;
    onehot[idx_p0] = 1'b1;
  end

  seven_segment_digit u_digit (
    .value    (digit_val),
    .suppress (lz_mask_s[idx_p0]),
    .abcdefg  (seg_dec)
  );

  // p0 -> p1: scan state and shadows feed the registered pin drivers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_p0         <= '0;
      idx_p0         <= '0;
      num_s          <= '0;
      dots_s         <= '0;
      blank_s        <= '0;
      lz_mask_s      <= '0;
      frame_start_p1 <= 1'b0;
      seg_p1         <= seg_pol(SEG_OFF, active_low);
      dot_p1         <= bit_pol(1'b0, active_low);
      an_p1          <= {n_digits{active_low}};
    end else begin
      cnt_p0 <= cnt_p0 + 1'b1;
      if (slot_end) idx_p0 <= (idx_p0 == idx_last) ? '0 : idx_p0 + 1'b1;
      if (frame_end) begin
        num_s     <= num;
        dots_s    <= dots;
        blank_s   <= blank;
        lz_mask_s <= lz_mask_d;
      end
      frame_start_p1 <= frame_end;
      seg_p1         <= seg_pol(lit ? seg_dec : SEG_OFF, active_low);
      dot_p1         <= bit_pol(lit & dots_s[idx_p0], active_low);
      an_p1          <= (lit ? onehot : '0) ^ {n_digits{active_low}};
    end
  end

  assign abcdefg     = seg_p1;
  assign dot         = dot_p1;
  assign anodes      = an_p1;
  assign frame_start = frame_start_p1;

endmodule

// File: tb/tb_seven_segment_scan.sv
// Directed bench for seven_segment_scan: 4 digits, 16-cycle slots, guard 1,
// one active-high and one active-low instance driven from the same inputs.
module tb_seven_segment_scan;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b1;
  logic        lz_en = 1'b0;
  logic [15:0] num = 16'h0;
  logic [3:0]  dots = 4'h0;
  logic [3:0]  blank = 4'h0;
  logic [1:0]  brightness = 2'd3;

  logic [6:0]  seg_h, seg_l;
  logic        dot_h, dot_l;
  logic [3:0]  an_h, an_l;
  logic        fs_h, fs_l;

  seven_segment_scan #(.n_digits(4), .bits_per_digit(4), .div_w(4), .bright_w(2),
                       .guard(1), .active_low(1'b0)) dut (
    .clk(clk), .reset(reset), .en(en), .num(num), .dots(dots), .blank(blank),
    .lz_en(lz_en), .brightness(brightness), .abcdefg(seg_h), .dot(dot_h),
    .anodes(an_h), .frame_start(fs_h));

  seven_segment_scan #(.n_digits(4), .bits_per_digit(4), .div_w(4), .bright_w(2),
                       .guard(1), .active_low(1'b1)) dut_al (
    .clk(clk), .reset(reset), .en(en), .num(num), .dots(dots), .blank(blank),
    .lz_en(lz_en), .brightness(brightness), .abcdefg(seg_l), .dot(dot_l),
    .anodes(an_l), .frame_start(fs_l));

  always #5 clk = ~clk;

  // cyc = k during scan cycle k; cycle 0 begins at the last reset edge.
  int cyc;
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [15:0] num;
    logic [3:0]  dots;
    logic [3:0]  blank;
    logic        lz;
    logic        en;
    logic [1:0]  br;
    int          slot;
    int          pos;
    logic [6:0]  seg;
    logic        dot;
    logic [3:0]  an;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input logic [15:0] v_num, input logic [3:0] v_dots,
                         input logic [3:0] v_blank, input logic v_lz, input logic v_en,
                         input logic [1:0] v_br, input int v_slot, input int v_pos,
                         input logic [6:0] v_seg, input logic v_dot, input logic [3:0] v_an);
    vec_t v;
    v.num = v_num; v.dots = v_dots; v.blank = v_blank; v.lz = v_lz; v.en = v_en;
    v.br = v_br; v.slot = v_slot; v.pos = v_pos; v.seg = v_seg; v.dot = v_dot; v.an = v_an;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int t);
    if (cyc > t) begin
      n_checks++;
      n_fail++;
      $display("FAIL schedule: at cycle %0d, required cycle %0d", cyc, t);
    end
    while (cyc < t) @(negedge clk);
  endtask

  // Checks both instances against one active-high expectation.
  task automatic check_out(input string name, input logic [6:0] seg, input logic d,
                           input logic [3:0] an);
    check({name, "_hi"}, {20'd0, seg_h, dot_h, an_h}, {20'd0, seg, d, an});
    check({name, "_lo"}, {20'd0, seg_l, dot_l, an_l}, {20'd0, ~seg, ~d, ~an});
  endtask

  function automatic int next_frame(input int c);
    return (c / 64 + 1) * 64;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required $finish");
    $fatal(1);
  end

  initial begin
    int s;
    int t;

    // Patterns and brightness windows, blanking, enable and polarity
    add_vec(16'h12AF, 4'h0, 4'h0, 1'b0, 1'b1, 2'd3, 0, 0,  7'b0000000, 1'b0, 4'b0000);
    add_vec(16'h12AF, 4'h0, 4'h0, 1'b0, 1'b1, 2'd3, 0, 1,  7'b1000111, 1'b0, 4'b0001);
    add_vec(16'h12AF, 4'h0, 4'h0, 1'b0, 1'b1, 2'd3, 0, 15, 7'b1000111, 1'b0, 4'b0001);
    add_vec(16'h12AF, 4'h0, 4'h0, 1'b0, 1'b1, 2'd3, 1, 5,  7'b1110111, 1'b0, 4'b0010);
    add_vec(16'h12AF, 4'h0, 4'h0, 1'b0, 1'b1, 2'd3, 2, 8,  7'b1101101, 1'b0, 4'b0100);
    add_vec(16'h12AF, 4'h0, 4'h0, 1'b0, 1'b1, 2'd3, 3, 15, 7'b0110000, 1'b0, 4'b1000);
    add_vec(16'h12AF, 4'h0, 4'h0, 1'b0, 1'b1, 2'd1, 0, 7,  7'b1000111, 1'b0, 4'b0001);
    add_vec(16'h12AF, 4'h0, 4'h0, 1'b0, 1'b1, 2'd1, 0, 8,  7'b0000000, 1'b0, 4'b0000);
    add_vec(16'h12AF, 4'h0, 4'h0, 1'b0, 1'b1, 2'd0, 1, 3,  7'b1110111, 1'b0, 4'b0010);
    add_vec(16'h12AF, 4'h0, 4'h0, 1'b0, 1'b1, 2'd0, 1, 4,  7'b0000000, 1'b0, 4'b0000);
    add_vec(16'h0030, 4'h8, 4'h0, 1'b1, 1'b1, 2'd3, 3, 2,  7'b0000000, 1'b1, 4'b1000);
    add_vec(16'h0030, 4'h8, 4'h0, 1'b1, 1'b1, 2'd3, 2, 2,  7'b0000000, 1'b0, 4'b0100);
    add_vec(16'h0030, 4'h8, 4'h0, 1'b1, 1'b1, 2'd3, 1, 2,  7'b1111001, 1'b0, 4'b0010);
    add_vec(16'h0030, 4'h8, 4'h0, 1'b1, 1'b1, 2'd3, 0, 2,  7'b1111110, 1'b0, 4'b0001);
    add_vec(16'h0000, 4'h0, 4'h0, 1'b1, 1'b1, 2'd3, 0, 3,  7'b1111110, 1'b0, 4'b0001);
    add_vec(16'h0000, 4'h0, 4'h0, 1'b1, 1'b1, 2'd3, 1, 3,  7'b0000000, 1'b0, 4'b0010);
    add_vec(16'h0000, 4'h0, 4'h0, 1'b1, 1'b1, 2'd3, 3, 3,  7'b0000000, 1'b0, 4'b1000);
    add_vec(16'h0030, 4'h0, 4'h0, 1'b0, 1'b1, 2'd3, 3, 3,  7'b1111110, 1'b0, 4'b1000);
    add_vec(16'h12AF, 4'h0, 4'h4, 1'b0, 1'b1, 2'd3, 2, 5,  7'b0000000, 1'b0, 4'b0000);
    add_vec(16'h12AF, 4'h0, 4'h4, 1'b0, 1'b1, 2'd3, 1, 5,  7'b1110111, 1'b0, 4'b0010);
    add_vec(16'h12AF, 4'h0, 4'h4, 1'b0, 1'b1, 2'd3, 3, 5,  7'b0110000, 1'b0, 4'b1000);
    add_vec(16'h12AF, 4'h1, 4'h0, 1'b0, 1'b0, 2'd3, 0, 5,  7'b0000000, 1'b0, 4'b0000);
    add_vec(16'h8888, 4'h1, 4'h0, 1'b0, 1'b1, 2'd3, 0, 5,  7'b1111111, 1'b1, 4'b0001);

    // Reset state
    num = 16'h8888;
    repeat (3) @(negedge clk);
    check("rst_fs_hi", {31'd0, fs_h}, 32'd0);
    check("rst_fs_lo", {31'd0, fs_l}, 32'd0);
    check_out("rst_out", 7'b0000000, 1'b0, 4'b0000);

    // Run from release: shadow is zero, first snapshot at the end of cycle 63
    reset = 1'b0;
    for (int c = 1; c <= 66; c++) begin
      wait_cyc(c);
      check($sformatf("fs_c%0d", c), {30'd0, fs_h, fs_l}, (c == 64) ? 32'd3 : 32'd0);
      if (c == 1) check_out("boot_guard", 7'b0000000, 1'b0, 4'b0000);
      if (c == 5) check_out("boot_d0", 7'b1111110, 1'b0, 4'b0001);
    end

    for (int i = 0; i < vq.size(); i++) begin
      num = vq[i].num; dots = vq[i].dots; blank = vq[i].blank;
      lz_en = vq[i].lz; en = vq[i].en; brightness = vq[i].br;
      s = next_frame(cyc);
      t = s + vq[i].slot * 16 + vq[i].pos + 1;
      wait_cyc(t);
      check_out($sformatf("vec%0d", i), vq[i].seg, vq[i].dot, vq[i].an);
    end

    // Mid-frame input change must not reach the display until the next frame
    num = 16'h12AF; dots = 4'h0; blank = 4'h0; lz_en = 1'b0; en = 1'b1; brightness = 2'd3;
    s = next_frame(cyc);
    wait_cyc(s + 20);
    check_out("tear_a0", 7'b1110111, 1'b0, 4'b0010);
    num = 16'h3456;
    wait_cyc(s + 26);
    check_out("tear_a1", 7'b1110111, 1'b0, 4'b0010);
    wait_cyc(s + 41);
    check_out("tear_2", 7'b1101101, 1'b0, 4'b0100);
    wait_cyc(s + 60);
    check_out("tear_1", 7'b0110000, 1'b0, 4'b1000);
    wait_cyc(s + 70);
    check_out("tear_new", 7'b1011111, 1'b0, 4'b0001);

    // Change on the snapshot edge is captured; one cycle later waits a frame
    s = next_frame(cyc);
    wait_cyc(s - 1);
    num = 16'h000B;
    wait_cyc(s);
    num = 16'h000C;
    wait_cyc(s + 6);
    check_out("edge_cap", 7'b0011111, 1'b0, 4'b0001);
    wait_cyc(s + 70);
    check_out("edge_late", 7'b1001110, 1'b0, 4'b0001);

    // Reset mid-slot while a digit is lit
    reset = 1'b1;
    @(negedge clk);
    check_out("midrst_out", 7'b0000000, 1'b0, 4'b0000);
    check("midrst_fs", {30'd0, fs_h, fs_l}, 32'd0);
    reset = 1'b0;
    wait_cyc(2);
    check_out("midrst_d0", 7'b1111110, 1'b0, 4'b0001);
    wait_cyc(18);
    check_out("midrst_d1", 7'b1111110, 1'b0, 4'b0010);
    wait_cyc(63);
    check("midrst_fs63", {30'd0, fs_h, fs_l}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_segment_scan.md
# seven_segment_scan

Parametrised multiplexed seven-segment display driver: the next-generation scan engine for the board display path. It owns its own refresh prescaler and scans `n_digits` hex digits one at a time. It adds tear-free frame snapshotting, per-digit blanking, leading-zero suppression, PWM brightness, anti-ghost dead time and selectable output polarity. It sits between the user number/dot registers and the top-level `HEX*`/anode pins.

## Interface

- `n_digits`, 8, number of digits scanned
- `bits_per_digit`, 4, bits per digit; only 4 is legal (hex decode)
- `w`, `n_digits * bits_per_digit`, width of `num`
- `div_w`, 10, slot length exponent; each digit slot lasts 2^`div_w` cycles
- `bright_w`, 4, brightness code width; `bright_w <= div_w` is required
- `guard`, 2, dead cycles at the start of every slot with all anodes off; `guard < 2^div_w` is required
- `active_low`, 1, 1 = anodes and segments driven active-low

- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `en`  in  1  display enable; 0 forces all outputs inactive, scan keeps running
- `num`  in  `w`  digit values; digit i = `num[4i+3:4i]`, digit 0 rightmost
- `dots`  in  `n_digits`  decimal point per digit
- `blank`  in  `n_digits`  1 = digit i dark
- `lz_en`  in  1  leading-zero suppression enable
- `brightness`  in  `bright_w`  duty code; all-ones = full duty
- `abcdefg`  out  7  segment drive; bit 6 = a
- `dot`  out  1  decimal point drive
- `anodes`  out  `n_digits`  digit select, one-hot when lit
- `frame_start`  out  1  one-cycle pulse after each snapshot

## Operation

- State: `cnt` (`div_w` bits, wraps naturally) and `idx` (0..`n_digits`-1). `cnt` increments every cycle. On `cnt` = max, `idx` increments and wraps from `n_digits`-1 to 0.
- Snapshot: on the edge where `idx` wraps to 0, `num`, `dots`, `blank` and `lz_en` are captured into shadow registers. The leading-zero mask is computed from the captured values and registered on the same edge. Inputs are ignored at all other times, so a frame never tears.
- Leading-zero mask: with `lz_en`=1, digits from `n_digits`-1 downward whose value is 0 are suppressed until the first nonzero digit. Digit 0 is never suppressed. A suppressed digit still shows its dot if its `dots` bit is set.
- Lit condition for digit `idx` in the current cycle: `en` and not `blank_s[idx]` and `cnt >= guard` and `cnt[div_w-1 -: bright_w] <= brightness`.
- Decode: standard hex, active-high patterns. 0 = 1111110, 1 = 0110000, 8 = 1111111, F = 1000111.
- Digit lit: `anodes` = one-hot at `idx`; `abcdefg` = decode, or all-off if LZ-suppressed; `dot` = `dots_s[idx]`. Digit not lit: all outputs inactive.
- `active_low`=1 inverts all three outputs at the register input. "Inactive" therefore means all ones.
- `brightness` is sampled live every cycle; it is not snapshotted.

## Timing

- Reset values: `cnt`=0, `idx`=0, shadows and LZ mask = 0, `frame_start`=0, all outputs inactive (all ones when `active_low`=1).
- Reset asserted mid-slot or mid-frame: outputs go inactive on the next edge, and the scan restarts at digit 0 with the shadow cleared.
- Outputs are registered, with 1-cycle latency from `(idx, cnt)` to pins.
- `frame_start` is high in the cycle with `idx`=0, `cnt`=0 that follows a snapshot edge. It is not asserted after reset, because no snapshot has been taken yet.
- Frame period = `n_digits` × 2^`div_w` cycles.
- Lit cycles per slot = 2^`div_w` × (`brightness`+1) / 2^`bright_w` − `guard`. When `brightness`=0 and `guard` ≥ lit window, the digit is dark.
- An input change on the snapshot edge itself is captured. A change one cycle later waits a full frame.

## Structure

- Shared package/header `seven_segment_pkg`: hex-to-segment constants, `SEG_OFF`, and polarity helper. It is shared with other display blocks.
- Sub-module: existing `seven_segment_digit` for the decode.
- Leading-zero mask generation is a small `for` loop in this module, not a separate module.

## Test plan

Default test configuration: `n_digits`=4, `div_w`=4, `bright_w`=2, `guard`=1, `active_low`=0.

- Reset, then run: outputs all 0 during reset; `frame_start` first pulses at cycle 64 after release; before that, digit 0 shows 0 (1111110) with `anodes`=0001.
- `num`=16'h12AF, `brightness`=3: per slot, anodes dark for 1 cycle, then lit 15 cycles. Slots show F, A, 2, 1 with anodes 0001, 0010, 0100, 1000.
- `lz_en`=1, `num`=16'h0030, `dots`=4'b1000: digits 3 and 2 are suppressed (digit 3 still drives `dot`=1), and digit 0 shows 0. With `num`=0, only digit 0 shows 0.
- `brightness`=1: lit window = cycles 1–7 of each slot (7 cycles). `brightness`=0: cycles 1–3 only.
- Change `num` mid-frame: the old value is held until the next snapshot, and no slot shows a mix of old and new values. `blank`=4'b0100 darkens digit 2 only.
- `active_low`=1: the reset state is all ones, and digit 8 drives `abcdefg`=0000000. Reset asserted mid-slot: outputs go inactive on the next edge and the scan restarts at digit 0.
